// File: rtl/sd_crc_lanes_if.sv
// Control and data bundle for sd_crc_lanes: shift/emit/step controls in,
// serial CRC bits, status flags and parallel CRC registers out.
interface sd_crc_lanes_if #(
  parameter int WIDTH = 7,
  parameter int LANES = 1
);
  logic                   i_clear;
  logic                   i_shift;
  logic [LANES-1:0]       i_data;
  logic                   i_emit;
  logic                   i_step;
  logic [LANES-1:0]       o_data;
  logic                   o_emit_busy;
  logic                   o_emit_done;
  logic                   o_overrun;
  logic [LANES-1:0]       o_zero;
  logic [LANES*WIDTH-1:0] o_crc;

  modport master (
    output i_clear, i_shift, i_data, i_emit, i_step,
    input  o_data, o_emit_busy, o_emit_done, o_overrun, o_zero, o_crc
  );

  modport slave (
    input  i_clear, i_shift, i_data, i_emit, i_step,
    output o_data, o_emit_busy, o_emit_done, o_overrun, o_zero, o_crc
  );
endinterface

// File: rtl/sd_crc_lanes.sv
// Multi-lane serial CRC engine for SD CMD (CRC7) and DAT (CRC16-CCITT):
// accumulates one bit per lane, then serialises each CRC MSB-first.
module sd_crc_lanes #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(7'h09),
  parameter int               LANES = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  sd_crc_lanes_if.slave bus
);

  localparam int             CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [LANES-1:0][WIDTH-1:0]    crc_q, crc_d;
  logic                           done_q, done_d;
  logic                           overrun_q, overrun_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      crc_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Emission reuses the CRC registers as the output shifter, so the final
  // step only has to clear whatever is left of the MSB.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (bus.i_clear) begin
      state_d   = IDLE;
      cnt_d     = '0;
      crc_d     = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (bus.i_emit) begin
            state_d = EMIT;
            cnt_d   = CNT_MAX;
            if (bus.i_shift) overrun_d = 1'b1;
          end else if (bus.i_shift) begin
            state_d = ACCUM;
            for (int n = 0; n < LANES; n++) begin
              crc_d[n] = {crc_q[n][WIDTH-2:0], 1'b0} ^
                         ({WIDTH{crc_q[n][WIDTH-1] ^ bus.i_data[n]}} & POLY);
            end
          end
        end
        EMIT: begin
          if (bus.i_shift) overrun_d = 1'b1;
          if (bus.i_step) begin
            if (cnt_q == '0) begin
              state_d = IDLE;
              crc_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CW'(1);
              for (int n = 0; n < LANES; n++) begin
                crc_d[n] = {crc_q[n][WIDTH-2:0], 1'b0};
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int n = 0; n < LANES; n++) begin
      bus.o_data[n] = (state_q == EMIT) ? crc_q[n][WIDTH-1] : 1'b0;
      bus.o_zero[n] = (crc_q[n] == '0);
    end
  end

  assign bus.o_emit_busy = (state_q == EMIT);
  assign bus.o_emit_done = done_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_crc       = crc_q;

endmodule
